msrh_sched_entry_nsrc: RTL and testbench

Parametrised scheduler entry for the issue queues: holds one dispatched micro-op with `NUM_SRC` source operands. Wakes it on early (speculative) and physical write-back tags, and requests issue. Replays it when a speculative producer mispredicts, and tracks it through completion to commit. Beyond the 2-source entry it adds:

- a configurable operand count;
- sticky speculative-ready bits with confirm/cancel;
- a saturating replay counter that forces non-speculative issue after `MAX_REPLAY` replays.

---
 rtl/msrh_pkg.sv | 30 +++
 rtl/msrh_tag_match.sv | 26 ++
 rtl/msrh_sched_entry_nsrc.sv | 239 +++++++++++++++++++++++
 tb/tb_msrh_sched_entry_nsrc.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/msrh_pkg.sv
// rtl/msrh_pkg.sv - shared scheduler types, default widths and the branch-flush helper
package msrh_pkg;

  localparam int DEF_RNID_W     = 7;
  localparam int DEF_CMT_ID_W   = 6;
  localparam int DEF_DISP_SIZE  = 4;
  localparam int DEF_BR_MASK_W  = 8;
  localparam int MAX_BR_MASK_W  = 64;
  localparam int MAX_BR_TAG_W   = 6;

  typedef logic [2:0] sched_state_t;

  localparam sched_state_t ST_INIT          = 3'd0;
  localparam sched_state_t ST_WAIT          = 3'd1;
  localparam sched_state_t ST_ISSUED        = 3'd2;
  localparam sched_state_t ST_DONE          = 3'd3;
  localparam sched_state_t ST_WAIT_COMPLETE = 3'd4;
  localparam sched_state_t ST_DEAD          = 3'd5;

  // Callers zero-extend their mask and tag to the widest supported branch mask.
  function automatic logic is_br_flush_target(
    input logic [MAX_BR_MASK_W-1:0] br_mask,
    input logic [MAX_BR_TAG_W-1:0]  br_tag,
    input logic                     br_upd,
    input logic                     br_mispred
  );
    return br_upd & br_mispred & br_mask[br_tag];
  endfunction

endpackage

// File: rtl/msrh_tag_match.sv
// rtl/msrh_tag_match.sv - compares one tag against a bus of write-back ports
module msrh_tag_match #(
  parameter int PORTS  = 4,
  parameter int RNID_W = 7
) (
  input  logic [RNID_W-1:0]       tag,
  input  logic [PORTS-1:0]        valid,
  input  logic [PORTS*RNID_W-1:0] rnid,
  input  logic [PORTS-1:0]        flag,
  output logic                    hit,
  output logic                    flagged_hit
);

  logic [PORTS-1:0] w_match;

  always_comb begin
    w_match = '0;
    for (int p = 0; p < PORTS; p++) begin
      w_match[p] = valid[p] & (rnid[p*RNID_W +: RNID_W] == tag);
    end
  end

  assign hit         = |w_match;
  assign flagged_hit = |(w_match & flag);

endmodule

// File: rtl/msrh_sched_entry_nsrc.sv
// rtl/msrh_sched_entry_nsrc.sv - one issue-queue entry with NUM_SRC operands, speculative wakeup and replay
module msrh_sched_entry_nsrc
  import msrh_pkg::*;
#(
  parameter int NUM_SRC    = 3,
  parameter int RNID_W     = DEF_RNID_W,
  parameter int CMT_ID_W   = DEF_CMT_ID_W,
  parameter int DISP_SIZE  = DEF_DISP_SIZE,
  parameter int BR_MASK_W  = DEF_BR_MASK_W,
  parameter int BR_TAG_W   = $clog2(BR_MASK_W),
  parameter int EWR_PORTS  = 4,
  parameter int PWR_PORTS  = 4,
  parameter int MIS_PORTS  = 2,
  parameter int EXC_W      = 5,
  parameter int MAX_REPLAY = 3,
  parameter int RPL_W      = $clog2(MAX_REPLAY + 1),
  parameter int EN_OLDEST  = 0
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_put,
  input  logic [CMT_ID_W-1:0]         i_put_cmt_id,
  input  logic [DISP_SIZE-1:0]        i_put_grp_id,
  input  logic [NUM_SRC-1:0]          i_put_src_valid,
  input  logic [NUM_SRC-1:0]          i_put_src_ready,
  input  logic [NUM_SRC*RNID_W-1:0]   i_put_src_rnid,
  input  logic [BR_MASK_W-1:0]        i_put_br_mask,
  input  logic [EWR_PORTS-1:0]        i_ewr_valid,
  input  logic [EWR_PORTS*RNID_W-1:0] i_ewr_rnid,
  input  logic [EWR_PORTS-1:0]        i_ewr_may_mispred,
  input  logic [PWR_PORTS-1:0]        i_pwr_valid,
  input  logic [PWR_PORTS*RNID_W-1:0] i_pwr_rnid,
  input  logic [MIS_PORTS-1:0]        i_mis_valid,
  input  logic [MIS_PORTS*RNID_W-1:0] i_mis_rnid,
  input  logic                        i_picked,
  input  logic                        i_pipe_done,
  input  logic                        i_pipe_except_valid,
  input  logic [EXC_W-1:0]            i_pipe_except_type,
  input  logic                        i_commit_valid,
  input  logic [CMT_ID_W-1:0]         i_commit_cmt_id,
  input  logic                        i_commit_flush,
  input  logic                        i_br_upd,
  input  logic [BR_TAG_W-1:0]         i_br_tag,
  input  logic                        i_br_mispred,
  input  logic [CMT_ID_W-1:0]         i_rob_head_cmt_id,
  input  logic [DISP_SIZE-1:0]        i_rob_done_grp,
  input  logic [DISP_SIZE-1:0]        i_rob_pc_upd_grp,
  output logic                        o_valid,
  output logic                        o_ready,
  output logic [NUM_SRC-1:0]          o_src_ready,
  output logic [NUM_SRC-1:0]          o_src_spec,
  output logic                        o_done,
  output logic                        o_wait_complete,
  output logic                        o_finish,
  output logic [CMT_ID_W-1:0]         o_cmt_id,
  output logic [DISP_SIZE-1:0]        o_grp_id,
  output logic [BR_MASK_W-1:0]        o_br_mask,
  output logic                        o_except_valid,
  output logic [EXC_W-1:0]            o_except_type,
  output logic [RPL_W-1:0]            o_replay_cnt
);

  localparam logic [RPL_W-1:0] MAX_RPL = RPL_W'(MAX_REPLAY);

  sched_state_t         r_state;
  sched_state_t         w_state_n;
  logic                 r_valid;
  logic [CMT_ID_W-1:0]  r_cmt_id;
  logic [DISP_SIZE-1:0] r_grp_id;
  logic [BR_MASK_W-1:0] r_br_mask;
  logic [NUM_SRC-1:0]   r_src_valid;
  logic [NUM_SRC-1:0]   r_ready;
  logic [NUM_SRC-1:0]   r_spec;
  logic [RNID_W-1:0]    r_rnid [NUM_SRC];
  logic [RPL_W-1:0]     r_replay_cnt;
  logic                 r_except_valid;
  logic [EXC_W-1:0]     r_except_type;

  logic                 put_en;
  logic                 put_kill;
  logic                 flush;
  logic                 commit_match;
  logic                 oldest_ok;
  logic                 pc_upd_before;
  logic                 replay_hit;
  logic                 all_usable;
  logic                 ready_w;
  logic                 to_init;
  logic                 ex_latch;
  logic [BR_MASK_W-1:0] br_clr;
  logic [DISP_SIZE-1:0] grp_below;

  logic [NUM_SRC-1:0]   ewr_hit, ewr_spec_hit, pwr_hit, pwr_cfm, mis_hit, mis_spec_hit;
  logic [NUM_SRC-1:0]   ready_n, spec_n, usable;

  assign put_en       = (r_state == ST_INIT) & i_put;
  assign put_kill     = is_br_flush_target(MAX_BR_MASK_W'(i_put_br_mask), MAX_BR_TAG_W'(i_br_tag),
                                           i_br_upd, i_br_mispred);
  assign flush        = r_valid & (i_commit_flush |
                        is_br_flush_target(MAX_BR_MASK_W'(r_br_mask), MAX_BR_TAG_W'(i_br_tag),
                                           i_br_upd, i_br_mispred));
  assign commit_match = i_commit_valid & (i_commit_cmt_id == r_cmt_id);
  assign br_clr       = i_br_upd ? (BR_MASK_W'(1) << i_br_tag) : '0;

  // Older group members must all be done; a PC-updating one among them blocks issue.
  assign grp_below     = r_grp_id - DISP_SIZE'(1);
  assign oldest_ok     = (EN_OLDEST == 0) |
                         ((i_rob_head_cmt_id == r_cmt_id) & ((i_rob_done_grp & grp_below) == grp_below));
  assign pc_upd_before = (EN_OLDEST != 0) & (|(grp_below & i_rob_pc_upd_grp & i_rob_done_grp));

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    logic [RNID_W-1:0] tag;
    logic              sv;
    logic              base_ready;
    logic              base_spec;

    assign tag        = put_en ? i_put_src_rnid[g*RNID_W +: RNID_W] : r_rnid[g];
    assign sv         = put_en ? i_put_src_valid[g] : r_src_valid[g];
    assign base_ready = put_en ? (i_put_src_ready[g] | ~i_put_src_valid[g]) : r_ready[g];
    assign base_spec  = put_en ? 1'b0 : r_spec[g];

    msrh_tag_match #(.PORTS(EWR_PORTS), .RNID_W(RNID_W)) u_ewr (
      .tag(tag), .valid(i_ewr_valid), .rnid(i_ewr_rnid), .flag(i_ewr_may_mispred),
      .hit(ewr_hit[g]), .flagged_hit(ewr_spec_hit[g])
    );
    msrh_tag_match #(.PORTS(PWR_PORTS), .RNID_W(RNID_W)) u_pwr (
      .tag(tag), .valid(i_pwr_valid), .rnid(i_pwr_rnid), .flag({PWR_PORTS{1'b1}}),
      .hit(pwr_hit[g]), .flagged_hit(pwr_cfm[g])
    );
    // Flagging by the held spec bit turns a mispredict match into a replay trigger.
    msrh_tag_match #(.PORTS(MIS_PORTS), .RNID_W(RNID_W)) u_mis (
      .tag(tag), .valid(i_mis_valid), .rnid(i_mis_rnid), .flag({MIS_PORTS{r_spec[g]}}),
      .hit(mis_hit[g]), .flagged_hit(mis_spec_hit[g])
    );

    assign ready_n[g] = base_ready | (sv & (pwr_hit[g] | (ewr_hit[g] & ~ewr_spec_hit[g])));
    assign spec_n[g]  = sv & ~base_ready & (base_spec | ewr_spec_hit[g]) & ~pwr_cfm[g] & ~mis_hit[g];
    assign usable[g]  = ready_n[g] | (spec_n[g] & (r_replay_cnt < MAX_RPL));
  end

  assign all_usable = &usable;
  assign replay_hit = |mis_spec_hit;
  assign ready_w    = r_valid & (r_state == ST_WAIT) & ~flush & oldest_ok & ~pc_upd_before & all_usable;

  always_comb begin
    w_state_n = r_state;
    ex_latch  = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (i_put) w_state_n = put_kill ? ST_DEAD : ST_WAIT;
      end
      ST_WAIT: begin
        if (flush)                        w_state_n = ST_DEAD;
        else if (ready_w & i_picked)      w_state_n = ST_ISSUED;
        else if (pc_upd_before & oldest_ok) w_state_n = ST_DONE;
      end
      ST_ISSUED: begin
        if (flush)           w_state_n = ST_DEAD;
        else if (replay_hit) w_state_n = ST_WAIT;
        else if (i_pipe_done) begin
          w_state_n = ST_DONE;
          ex_latch  = 1'b1;
        end
      end
      ST_DONE: begin
        if (commit_match) w_state_n = ST_INIT;
        else if (flush)   w_state_n = ST_DEAD;
        else              w_state_n = ST_WAIT_COMPLETE;
      end
      ST_WAIT_COMPLETE, ST_DEAD: begin
        if (commit_match) w_state_n = ST_INIT;
      end
      default: w_state_n = ST_INIT;
    endcase
  end

  assign to_init = (r_state != ST_INIT) & (w_state_n == ST_INIT);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= ST_INIT;
      r_valid        <= 1'b0;
      r_cmt_id       <= '0;
      r_grp_id       <= '0;
      r_br_mask      <= '0;
      r_src_valid    <= '0;
      r_ready        <= '0;
      r_spec         <= '0;
      r_replay_cnt   <= '0;
      r_except_valid <= 1'b0;
      r_except_type  <= '0;
      for (int s = 0; s < NUM_SRC; s++) r_rnid[s] <= '0;
    end else begin
      r_state   <= w_state_n;
      r_br_mask <= (put_en ? i_put_br_mask : r_br_mask) & ~br_clr;
      if (put_en) begin
        r_valid        <= 1'b1;
        r_cmt_id       <= i_put_cmt_id;
        r_grp_id       <= i_put_grp_id;
        r_src_valid    <= i_put_src_valid;
        r_replay_cnt   <= '0;
        r_except_valid <= 1'b0;
        r_except_type  <= '0;
        for (int s = 0; s < NUM_SRC; s++) r_rnid[s] <= i_put_src_rnid[s*RNID_W +: RNID_W];
      end else if (to_init) begin
        r_valid      <= 1'b0;
        r_cmt_id     <= '0;
        r_grp_id     <= '0;
        r_replay_cnt <= '0;
      end else if ((r_state == ST_ISSUED) & ~flush & replay_hit & (r_replay_cnt != MAX_RPL)) begin
        r_replay_cnt <= r_replay_cnt + RPL_W'(1);
      end
      if (ex_latch) begin
        r_except_valid <= i_pipe_except_valid;
        r_except_type  <= i_pipe_except_type;
      end
      if (put_en | r_valid) begin
        r_ready <= ready_n;
        r_spec  <= to_init ? '0 : spec_n;
      end
    end
  end

  assign o_valid         = r_valid;
  assign o_ready         = ready_w;
  assign o_src_ready     = (put_en | r_valid) ? ready_n : '0;
  assign o_src_spec      = (put_en | r_valid) ? spec_n : '0;
  assign o_done          = (r_state == ST_DONE) & ~flush;
  assign o_wait_complete = (r_state == ST_WAIT_COMPLETE);
  assign o_finish        = ((r_state == ST_DEAD) | (r_state == ST_DONE) |
                            (r_state == ST_WAIT_COMPLETE)) & commit_match;
  assign o_cmt_id        = r_cmt_id;
  assign o_grp_id        = r_grp_id;
  assign o_br_mask       = r_br_mask;
  assign o_except_valid  = r_except_valid;
  assign o_except_type   = r_except_type;
  assign o_replay_cnt    = r_replay_cnt;

endmodule

// File: tb/tb_msrh_sched_entry_nsrc.sv
// tb/tb_msrh_sched_entry_nsrc.sv - directed self-checking bench for msrh_sched_entry_nsrc
module tb_msrh_sched_entry_nsrc;

  logic        clk = 1'b0;
  logic        reset;
  logic        put, put_b;
  logic [5:0]  put_cmt_id;
  logic [3:0]  put_grp_id;
  logic [2:0]  put_src_valid, put_src_ready;
  logic [20:0] put_src_rnid;
  logic [7:0]  put_br_mask;
  logic [3:0]  ewr_valid, ewr_may_mispred;
  logic [27:0] ewr_rnid;
  logic [3:0]  pwr_valid;
  logic [27:0] pwr_rnid;
  logic [1:0]  mis_valid;
  logic [13:0] mis_rnid;
  logic        picked, pipe_done, pipe_except_valid;
  logic [4:0]  pipe_except_type;
  logic        commit_valid, commit_flush;
  logic [5:0]  commit_cmt_id, rob_head_cmt_id;
  logic        br_upd, br_mispred;
  logic [2:0]  br_tag;
  logic [3:0]  rob_done_grp, rob_pc_upd_grp;

  logic        valid_a, ready_a, done_a, wc_a, finish_a, exv_a;
  logic [2:0]  src_ready_a, src_spec_a;
  logic [5:0]  cmt_a;
  logic [3:0]  grp_a;
  logic [7:0]  brm_a;
  logic [4:0]  ext_a;
  logic [1:0]  rpl_a;
  logic        valid_b, ready_b, done_b, wc_b, finish_b, exv_b;
  logic [2:0]  src_ready_b, src_spec_b;
  logic [5:0]  cmt_b;
  logic [3:0]  grp_b;
  logic [7:0]  brm_b;
  logic [4:0]  ext_b;
  logic [1:0]  rpl_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  msrh_sched_entry_nsrc #(.NUM_SRC(3), .EN_OLDEST(0)) u_dut (
    .i_clk(clk), .i_reset(reset), .i_put(put), .i_put_cmt_id(put_cmt_id), .i_put_grp_id(put_grp_id),
    .i_put_src_valid(put_src_valid), .i_put_src_ready(put_src_ready), .i_put_src_rnid(put_src_rnid),
    .i_put_br_mask(put_br_mask), .i_ewr_valid(ewr_valid), .i_ewr_rnid(ewr_rnid),
    .i_ewr_may_mispred(ewr_may_mispred), .i_pwr_valid(pwr_valid), .i_pwr_rnid(pwr_rnid),
    .i_mis_valid(mis_valid), .i_mis_rnid(mis_rnid), .i_picked(picked), .i_pipe_done(pipe_done),
    .i_pipe_except_valid(pipe_except_valid), .i_pipe_except_type(pipe_except_type),
    .i_commit_valid(commit_valid), .i_commit_cmt_id(commit_cmt_id), .i_commit_flush(commit_flush),
    .i_br_upd(br_upd), .i_br_tag(br_tag), .i_br_mispred(br_mispred),
    .i_rob_head_cmt_id(rob_head_cmt_id), .i_rob_done_grp(rob_done_grp), .i_rob_pc_upd_grp(rob_pc_upd_grp),
    .o_valid(valid_a), .o_ready(ready_a), .o_src_ready(src_ready_a), .o_src_spec(src_spec_a),
    .o_done(done_a), .o_wait_complete(wc_a), .o_finish(finish_a), .o_cmt_id(cmt_a), .o_grp_id(grp_a),
    .o_br_mask(brm_a), .o_except_valid(exv_a), .o_except_type(ext_a), .o_replay_cnt(rpl_a)
  );

  msrh_sched_entry_nsrc #(.NUM_SRC(3), .EN_OLDEST(1)) u_dut_old (
    .i_clk(clk), .i_reset(reset), .i_put(put_b), .i_put_cmt_id(put_cmt_id), .i_put_grp_id(put_grp_id),
    .i_put_src_valid(put_src_valid), .i_put_src_ready(put_src_ready), .i_put_src_rnid(put_src_rnid),
    .i_put_br_mask(put_br_mask), .i_ewr_valid(ewr_valid), .i_ewr_rnid(ewr_rnid),
    .i_ewr_may_mispred(ewr_may_mispred), .i_pwr_valid(pwr_valid), .i_pwr_rnid(pwr_rnid),
    .i_mis_valid(mis_valid), .i_mis_rnid(mis_rnid), .i_picked(picked), .i_pipe_done(pipe_done),
    .i_pipe_except_valid(pipe_except_valid), .i_pipe_except_type(pipe_except_type),
    .i_commit_valid(commit_valid), .i_commit_cmt_id(commit_cmt_id), .i_commit_flush(commit_flush),
    .i_br_upd(br_upd), .i_br_tag(br_tag), .i_br_mispred(br_mispred),
    .i_rob_head_cmt_id(rob_head_cmt_id), .i_rob_done_grp(rob_done_grp), .i_rob_pc_upd_grp(rob_pc_upd_grp),
    .o_valid(valid_b), .o_ready(ready_b), .o_src_ready(src_ready_b), .o_src_spec(src_spec_b),
    .o_done(done_b), .o_wait_complete(wc_b), .o_finish(finish_b), .o_cmt_id(cmt_b), .o_grp_id(grp_b),
    .o_br_mask(brm_b), .o_except_valid(exv_b), .o_except_type(ext_b), .o_replay_cnt(rpl_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    put = 0; put_b = 0; picked = 0; pipe_done = 0; pipe_except_valid = 0; pipe_except_type = '0;
    ewr_valid = '0; ewr_may_mispred = '0; ewr_rnid = '0; pwr_valid = '0; pwr_rnid = '0;
    mis_valid = '0; mis_rnid = '0; commit_valid = 0; commit_cmt_id = '0; commit_flush = 0;
    br_upd = 0; br_tag = '0; br_mispred = 0;
  endtask

  task automatic do_put(input logic [5:0] id, input logic [2:0] sv, input logic [2:0] sr,
                        input logic [20:0] rn, input logic [7:0] mask);
    put = 1; put_cmt_id = id; put_grp_id = 4'b0001; put_src_valid = sv; put_src_ready = sr;
    put_src_rnid = rn; put_br_mask = mask;
  endtask

  task automatic ewr_spec_pick();
    ewr_valid = 4'b0010; ewr_rnid = {7'h0, 7'h0, 7'h12, 7'h0}; ewr_may_mispred = 4'b0010; #1;
    chk("spec_wake_ready", {31'b0, ready_a}, 32'd1);
    picked = 1;
    tick(); idle();
  endtask

  initial begin
    idle();
    put_cmt_id = '0; put_grp_id = '0; put_src_valid = '0; put_src_ready = '0; put_src_rnid = '0;
    put_br_mask = '0; rob_head_cmt_id = '0; rob_done_grp = '0; rob_pc_upd_grp = '0;
    reset = 1;
    tick(); tick();
    reset = 0;
    chk("rst_valid", {31'b0, valid_a}, 32'd0);
    chk("rst_ready", {31'b0, ready_a}, 32'd0);
    chk("rst_done", {31'b0, done_a}, 32'd0);
    chk("rst_finish", {31'b0, finish_a}, 32'd0);
    chk("rst_rpl", {30'b0, rpl_a}, 32'd0);
    chk("rst_src_ready", {29'b0, src_ready_a}, 32'd0);
    chk("rst_brmask", {24'b0, brm_a}, 32'd0);
    chk("rst_valid_b", {31'b0, valid_b}, 32'd0);

    // Two-wakeup issue: src0 ready, src1/src2 wait on 0x12/0x13
    do_put(6'd3, 3'b111, 3'b001, {7'h13, 7'h12, 7'h05}, 8'h00); #1;
    chk("put_valid_same_cycle", {31'b0, valid_a}, 32'd0);
    tick(); idle();
    chk("put_valid", {31'b0, valid_a}, 32'd1);
    chk("put_cmt", {26'b0, cmt_a}, 32'd3);
    chk("put_src_ready", {29'b0, src_ready_a}, 32'b001);
    chk("put_not_ready", {31'b0, ready_a}, 32'd0);
    pwr_valid = 4'b0001; pwr_rnid = {7'h0, 7'h0, 7'h0, 7'h12}; #1;
    chk("first_pwr_ready", {31'b0, ready_a}, 32'd0);
    chk("first_pwr_src", {29'b0, src_ready_a}, 32'b011);
    tick(); idle();
    pwr_valid = 4'b0100; pwr_rnid = {7'h0, 7'h13, 7'h0, 7'h0}; #1;
    chk("second_pwr_ready", {31'b0, ready_a}, 32'd1);
    tick(); idle();
    picked = 1; #1;
    chk("pick_ready", {31'b0, ready_a}, 32'd1);
    tick(); idle();
    chk("issued_not_ready", {31'b0, ready_a}, 32'd0);
    pipe_done = 1; pipe_except_valid = 1; pipe_except_type = 5'd7;
    tick(); idle();
    chk("done_pulse", {31'b0, done_a}, 32'd1);
    chk("except_type", {27'b0, ext_a}, 32'd7);
    chk("except_valid", {31'b0, exv_a}, 32'd1);
    tick();
    chk("done_one_cycle", {31'b0, done_a}, 32'd0);
    chk("wait_complete", {31'b0, wc_a}, 32'd1);
    commit_valid = 1; commit_cmt_id = 6'd3; #1;
    chk("finish_wc", {31'b0, finish_a}, 32'd1);
    tick(); idle();
    chk("init_after_commit", {31'b0, valid_a}, 32'd0);

    // Speculative issue and replay up to the limit
    do_put(6'd8, 3'b111, 3'b101, {7'h20, 7'h12, 7'h21}, 8'h00);
    tick(); idle();
    chk("rp_put_not_ready", {31'b0, ready_a}, 32'd0);
    ewr_spec_pick();
    chk("rp_issued_spec", {29'b0, src_spec_a}, 32'b010);
    mis_valid = 2'b01; mis_rnid = {7'h0, 7'h12};
    tick(); idle();
    chk("rp_cnt1", {30'b0, rpl_a}, 32'd1);
    chk("rp_spec_cleared", {29'b0, src_spec_a}, 32'b000);
    ewr_spec_pick();
    mis_valid = 2'b10; mis_rnid = {7'h12, 7'h0}; pipe_done = 1;
    tick(); idle();
    chk("rp_cnt2", {30'b0, rpl_a}, 32'd2);
    chk("rp_beats_done", {31'b0, done_a}, 32'd0);
    ewr_spec_pick();
    mis_valid = 2'b01; mis_rnid = {7'h0, 7'h12};
    tick(); idle();
    chk("rp_cnt3", {30'b0, rpl_a}, 32'd3);
    ewr_valid = 4'b0001; ewr_rnid = {7'h0, 7'h0, 7'h0, 7'h12}; ewr_may_mispred = 4'b0001; #1;
    chk("rp_conservative", {31'b0, ready_a}, 32'd0);
    chk("rp_spec_seen", {29'b0, src_spec_a}, 32'b010);
    tick(); idle();
    pwr_valid = 4'b1000; pwr_rnid = {7'h12, 7'h0, 7'h0, 7'h0}; #1;
    chk("rp_pwr_ready", {31'b0, ready_a}, 32'd1);
    tick(); idle();
    chk("rp_cnt_held", {30'b0, rpl_a}, 32'd3);
    reset = 1;
    tick();
    reset = 0;
    chk("midop_reset_valid", {31'b0, valid_a}, 32'd0);
    chk("midop_reset_cnt", {30'b0, rpl_a}, 32'd0);

    // Branch mispredict kills an issued entry
    do_put(6'd9, 3'b111, 3'b111, {7'h1, 7'h2, 7'h3}, 8'h04);
    tick(); idle();
    chk("br_mask", {24'b0, brm_a}, 32'h04);
    picked = 1;
    tick(); idle();
    br_upd = 1; br_tag = 3'd2; br_mispred = 1; pipe_done = 1;
    tick(); idle();
    chk("br_dead_valid", {31'b0, valid_a}, 32'd1);
    chk("br_mask_cleared", {24'b0, brm_a}, 32'h00);
    chk("br_no_done", {31'b0, done_a}, 32'd0);
    commit_valid = 1; commit_cmt_id = 6'd8; #1;
    chk("dead_wrong_id", {31'b0, finish_a}, 32'd0);
    commit_cmt_id = 6'd9; #1;
    chk("dead_finish", {31'b0, finish_a}, 32'd1);
    tick(); idle();
    chk("dead_to_init", {31'b0, valid_a}, 32'd0);

    // Put killed by same-cycle branch mispredict
    do_put(6'd10, 3'b000, 3'b000, '0, 8'h02);
    br_upd = 1; br_tag = 3'd1; br_mispred = 1;
    tick(); idle();
    chk("putkill_ready", {31'b0, ready_a}, 32'd0);
    commit_valid = 1; commit_cmt_id = 6'd10; #1;
    chk("putkill_finish", {31'b0, finish_a}, 32'd1);
    tick(); idle();

    // Oldest-in-ROB entry completes without issue behind a PC update
    put_b = 1; put_cmt_id = 6'd5; put_grp_id = 4'b0100; put_src_valid = 3'b111; put_src_ready = 3'b111;
    put_br_mask = 8'h00; rob_head_cmt_id = 6'd5; rob_done_grp = 4'b0011; rob_pc_upd_grp = 4'b0000;
    tick(); idle();
    chk("old_ready", {31'b0, ready_b}, 32'd1);
    rob_pc_upd_grp = 4'b0001; #1;
    chk("old_pc_upd_blocks", {31'b0, ready_b}, 32'd0);
    tick();
    chk("old_done", {31'b0, done_b}, 32'd1);
    commit_valid = 1; commit_cmt_id = 6'd5; #1;
    chk("old_finish", {31'b0, finish_b}, 32'd1);
    tick(); idle();
    chk("old_init", {31'b0, valid_b}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
